// File: rtl/tc_pkg.sv
// Shared types and constants for the dual-port RAM and its clear sequencer.
package tc_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } tc_state_e;

  localparam int RDW_OLD    = 0;
  localparam int RDW_NEW    = 1;
  localparam int DEF_DWIDTH = 16;
  localparam int DEF_AWIDTH = 12;

endpackage

// File: rtl/tc_ram_dp_if.sv
// Bus bundle for both RAM ports plus the shared busy/err status lines.
interface tc_ram_dp_if
  import tc_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) ();

  logic              a_en;
  logic              a_load;
  logic [AWIDTH-1:0] a_addr;
  logic [DWIDTH-1:0] a_d;
  logic [DWIDTH-1:0] a_q;
  logic              a_valid;

  logic              b_en;
  logic              b_load;
  logic [AWIDTH-1:0] b_addr;
  logic [DWIDTH-1:0] b_d;
  logic [DWIDTH-1:0] b_q;
  logic              b_valid;

  logic              busy;
  logic              err;

  modport master (
    output a_en, a_load, a_addr, a_d,
    input  a_q, a_valid,
    output b_en, b_load, b_addr, b_d,
    input  b_q, b_valid,
    input  busy, err
  );

  modport slave (
    input  a_en, a_load, a_addr, a_d,
    output a_q, a_valid,
    input  b_en, b_load, b_addr, b_d,
    output b_q, b_valid,
    output busy, err
  );

endinterface

// File: rtl/tc_ram_clr_seq.sv
// Post-reset clear sweep: walks every word once, then hands the RAM over to the ports.
module tc_ram_clr_seq
  import tc_pkg::*;
#(
  parameter int AWIDTH         = DEF_AWIDTH,
  parameter int WORDS          = 2 ** DEF_AWIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  output logic              clr_we,
  output logic [AWIDTH-1:0] clr_addr
);

  // One extra pointer bit keeps the terminal count exact when WORDS == 2**AWIDTH.
  localparam logic [AWIDTH:0] LAST      = (AWIDTH + 1)'(WORDS - 1);
  localparam tc_state_e       RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  tc_state_e       state_reg;
  logic [AWIDTH:0] ptr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RST_STATE;
      ptr_reg   <= '0;
    end else if (state_reg == ST_CLEAR) begin
      ptr_reg <= ptr_reg + 1'b1;
      if (ptr_reg == LAST) state_reg <= ST_READY;
    end
  end

  assign busy     = (state_reg == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = ptr_reg[AWIDTH-1:0];

endmodule

// File: rtl/tc_ram_dp.sv
// Dual-port synchronous RAM: port A for the CPU, port B for loader/debug, with
// post-reset clear, selectable read-during-write and address range checking.
module tc_ram_dp
  import tc_pkg::*;
#(
  parameter int                DWIDTH         = DEF_DWIDTH,
  parameter int                AWIDTH         = DEF_AWIDTH,
  parameter int                WORDS          = 2 ** DEF_AWIDTH,
  parameter int                RDW_MODE       = RDW_OLD,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DWIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  tc_ram_dp_if.slave bus
);

  localparam int              IW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [AWIDTH:0] WORDS_L = (AWIDTH + 1)'(WORDS);

  logic [DWIDTH-1:0] mem [0:WORDS-1];

  logic              busy;
  logic              clr_we;
  logic [AWIDTH-1:0] clr_addr;
  logic [DWIDTH-1:0] a_q_reg, a_q_next, b_q_reg, b_q_next;
  logic              a_valid_reg, b_valid_reg, err_reg;

  tc_ram_clr_seq #(
    .AWIDTH        (AWIDTH),
    .WORDS         (WORDS),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clr_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  // Only the low IW address bits index the array; range checks use the full address.
  logic          unused_clr_addr;
  logic [IW-1:0] a_idx, b_idx, clr_idx;
  assign unused_clr_addr = ^clr_addr;
  assign clr_idx         = clr_addr[IW-1:0];
  assign a_idx           = bus.a_addr[IW-1:0];
  assign b_idx           = bus.b_addr[IW-1:0];

  logic a_req, a_in, a_wr, a_rd;
  logic b_req, b_in, b_wr_req, b_wr, b_drop, b_rd;
  logic same_addr, err_next;

  assign same_addr = (bus.a_addr == bus.b_addr);
  assign a_req     = !busy && bus.a_en;
  assign b_req     = !busy && bus.b_en;
  assign a_in      = ({1'b0, bus.a_addr} < WORDS_L);
  assign b_in      = ({1'b0, bus.b_addr} < WORDS_L);
  assign a_wr      = a_req && bus.a_load && a_in;
  assign a_rd      = a_req && !bus.a_load;
  assign b_wr_req  = b_req && bus.b_load && b_in;
  assign b_drop    = b_wr_req && a_wr && same_addr;  // A wins a write collision
  assign b_wr      = b_wr_req && !b_drop;
  assign b_rd      = b_req && !bus.b_load;
  assign err_next  = (a_req && !a_in) || (b_req && !b_in) || b_drop;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= CLEAR_VALUE;
    end else begin
      if (a_wr) mem[a_idx] <= bus.a_d;
      if (b_wr) mem[b_idx] <= bus.b_d;
    end
  end

  // Next q values: reads see old data, or the other port's write data in write-first mode.
  always_comb begin
    a_q_next = a_q_reg;
    b_q_next = b_q_reg;
    if (a_rd) begin
      if (!a_in)                                         a_q_next = '0;
      else if (RDW_MODE == RDW_NEW && b_wr && same_addr) a_q_next = bus.b_d;
      else                                               a_q_next = mem[a_idx];
    end else if (a_wr) begin
      a_q_next = (RDW_MODE == RDW_NEW) ? bus.a_d : mem[a_idx];
    end
    if (b_rd) begin
      if (!b_in)                                         b_q_next = '0;
      else if (RDW_MODE == RDW_NEW && a_wr && same_addr) b_q_next = bus.a_d;
      else                                               b_q_next = mem[b_idx];
    end else if (b_wr_req) begin
      if (RDW_MODE == RDW_NEW) b_q_next = b_drop ? bus.a_d : bus.b_d;
      else                     b_q_next = mem[b_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q_reg     <= '0;
      b_q_reg     <= '0;
      a_valid_reg <= 1'b0;
      b_valid_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      a_q_reg     <= a_q_next;
      b_q_reg     <= b_q_next;
      a_valid_reg <= a_rd;
      b_valid_reg <= b_rd;
      err_reg     <= err_next;
    end
  end

  assign bus.a_q     = a_q_reg;
  assign bus.b_q     = b_q_reg;
  assign bus.a_valid = a_valid_reg;
  assign bus.b_valid = b_valid_reg;
  assign bus.err     = err_reg;
  assign bus.busy    = busy;

endmodule

// File: tb/tb_tc_ram_dp.sv
// Directed bench for tc_ram_dp: three instances cover clear, RDW old/new and range checks.
module tb_tc_ram_dp;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  tc_ram_dp_if #(.DWIDTH(16), .AWIDTH(12)) if0 ();
  tc_ram_dp_if #(.DWIDTH(16), .AWIDTH(12)) if1 ();
  tc_ram_dp_if #(.DWIDTH(16), .AWIDTH(4))  if2 ();

  tc_ram_dp #(.DWIDTH(16), .AWIDTH(12), .WORDS(16), .RDW_MODE(0),
              .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  tc_ram_dp #(.DWIDTH(16), .AWIDTH(12), .WORDS(16), .RDW_MODE(1),
              .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'h0000))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  tc_ram_dp #(.DWIDTH(16), .AWIDTH(4), .WORDS(12), .RDW_MODE(0),
              .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'h0000))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("  ok   %s = %h", tag, got);
    end
  endtask

  task automatic idle_all();
    if0.a_en = 0; if0.a_load = 0; if0.a_addr = '0; if0.a_d = '0;
    if0.b_en = 0; if0.b_load = 0; if0.b_addr = '0; if0.b_d = '0;
    if1.a_en = 0; if1.a_load = 0; if1.a_addr = '0; if1.a_d = '0;
    if1.b_en = 0; if1.b_load = 0; if1.b_addr = '0; if1.b_d = '0;
    if2.a_en = 0; if2.a_load = 0; if2.a_addr = '0; if2.a_d = '0;
    if2.b_en = 0; if2.b_load = 0; if2.b_addr = '0; if2.b_d = '0;
  endtask

  int  cnt0, cnt1, cnt2;
  logic any_evt;

  initial begin
    idle_all();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy0", if0.busy, 1);
    check("rst_busy2", if2.busy, 1);
    check("rst_a_q0", if0.a_q, 0);
    check("rst_b_q0", if0.b_q, 0);
    check("rst_valid0", {if0.a_valid, if0.b_valid}, 0);
    check("rst_err0", if0.err, 0);

    // Release, let the sweep reach pointer 6, then reset again mid-sweep.
    @(negedge clk);
    rst_n = 1'b1;
    if0.a_en = 1; if0.a_load = 1; if0.a_addr = 12'd3; if0.a_d = 16'hBEEF;
    if0.b_en = 1; if0.b_load = 0; if0.b_addr = 12'd3;
    repeat (6) @(posedge clk);
    #1;
    check("mid_busy0", if0.busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy0", if0.busy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cnt0 = 0; cnt1 = 0; cnt2 = 0; any_evt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 16) begin
        if0.a_en = 0; if0.b_en = 0;
      end
      if (if0.busy) cnt0++;
      if (if1.busy) cnt1++;
      if (if2.busy) cnt2++;
      if (k <= 16) any_evt = any_evt | if0.a_valid | if0.b_valid | if0.err;
      @(negedge clk);
    end
    check("busy_cycles0", cnt0, 16);
    check("busy_cycles1", cnt1, 16);
    check("busy_cycles2", cnt2, 12);
    check("busy_no_evt", any_evt, 0);

    // Every word of dut0 swept to A5A5; addr 3 proves the busy-time write was dropped.
    for (int i = 0; i < 16; i++) begin
      if0.b_en = 1; if0.b_load = 0; if0.b_addr = 12'(i);
      @(negedge clk);
      check($sformatf("clr_rd%0d", i), {if0.b_valid, if0.b_q}, {1'b1, 16'hA5A5});
    end
    if0.b_en = 0;

    // Basic write/read on port A, read-first same-port update.
    if0.a_en = 1; if0.a_load = 1; if0.a_addr = 12'h000; if0.a_d = 16'hD000;
    @(negedge clk);
    check("wr0_old_q", {if0.a_valid, if0.a_q}, {1'b0, 16'hA5A5});
    if0.a_addr = 12'h00C; if0.a_d = 16'h300C;
    @(negedge clk);
    if0.a_load = 0; if0.a_addr = 12'h000;
    @(negedge clk);
    check("rd_000", {if0.a_valid, if0.a_q}, {1'b1, 16'hD000});
    if0.a_addr = 12'h00C;
    @(negedge clk);
    check("rd_00C", {if0.a_valid, if0.a_q}, {1'b1, 16'h300C});
    if0.a_en = 0;
    @(negedge clk);
    check("q_hold", {if0.a_valid, if0.a_q}, {1'b0, 16'h300C});

    // Write collision at address 7: A wins, err pulses once.
    if0.a_en = 1; if0.a_load = 1; if0.a_addr = 12'd7; if0.a_d = 16'h1111;
    if0.b_en = 1; if0.b_load = 1; if0.b_addr = 12'd7; if0.b_d = 16'h2222;
    @(negedge clk);
    check("coll_err", if0.err, 1);
    check("coll_b_q_old", if0.b_q, 16'hA5A5);
    if0.a_load = 0; if0.b_load = 0;
    @(negedge clk);
    check("coll_err_gone", if0.err, 0);
    check("coll_rd_a", if0.a_q, 16'h1111);
    check("coll_rd_b", if0.b_q, 16'h1111);
    if0.a_en = 0; if0.b_en = 0;

    // Range checks on the 12-word instance.
    if2.a_en = 1; if2.a_load = 1; if2.a_addr = 4'd11; if2.a_d = 16'h4444;
    @(negedge clk);
    check("rng_wr11_err", if2.err, 0);
    if2.a_load = 0;
    @(negedge clk);
    check("rng_rd11", {if2.a_valid, if2.err, if2.a_q}, {2'b10, 16'h4444});
    if2.a_load = 1; if2.a_addr = 4'd13; if2.a_d = 16'hFFFF;
    @(negedge clk);
    check("rng_wr13_err", {if2.a_valid, if2.err}, 2'b01);
    if2.a_load = 0;
    @(negedge clk);
    check("rng_rd13", {if2.a_valid, if2.err, if2.a_q}, {2'b11, 16'h0000});
    if2.a_en = 0;
    if2.b_en = 1; if2.b_load = 0; if2.b_addr = 4'd12;
    @(negedge clk);
    check("rng_b_rd12", {if2.b_valid, if2.err, if2.b_q}, {2'b11, 16'h0000});
    for (int i = 0; i < 12; i++) begin
      if2.b_addr = 4'(i);
      @(negedge clk);
      check($sformatf("rng_keep%0d", i), {if2.b_valid, if2.err, if2.b_q},
            {2'b10, (i == 11) ? 16'h4444 : 16'h0000});
    end
    if2.b_en = 0;

    // Read-during-write across ports at address 5: old data vs new data.
    if1.a_en = 1; if1.a_load = 1; if1.a_addr = 12'd5; if1.a_d = 16'h1234;
    if1.b_en = 1; if1.b_load = 0; if1.b_addr = 12'd5;
    if2.a_en = 1; if2.a_load = 1; if2.a_addr = 4'd5;  if2.a_d = 16'h1234;
    if2.b_en = 1; if2.b_load = 0; if2.b_addr = 4'd5;
    @(negedge clk);
    check("rdw_new_b", {if1.b_valid, if1.b_q}, {1'b1, 16'h1234});
    check("rdw_new_a", {if1.a_valid, if1.a_q}, {1'b0, 16'h1234});
    check("rdw_old_b", {if2.b_valid, if2.b_q}, {1'b1, 16'h0000});
    check("rdw_old_a", {if2.a_valid, if2.a_q}, {1'b0, 16'h0000});
    if1.a_en = 0; if2.a_en = 0;
    @(negedge clk);
    check("rdw_after_new", if1.b_q, 16'h1234);
    check("rdw_after_old", if2.b_q, 16'h1234);
    idle_all();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tc_ram_dp.md
Name: tc_ram_dp

Overview:
- Parametrised dual-port synchronous RAM; successor to the single-port CPU memory.
- Port A serves the CPU datapath (fetch/load/store). Port B serves the program loader / debug path.
- Adds a hardware clear sequencer after reset (replaces simulation-only initialisation), configurable read-during-write semantics, address-range checking and per-port read-valid strobes.

Parameters:
- DWIDTH, 16, data word width in bits
- AWIDTH, 12, address width in bits
- WORDS, 4096, implemented depth; must satisfy 1 <= WORDS <= 2**AWIDTH
- RDW_MODE, 0, read-during-write result: 0 = old data (read-first), 1 = new data (write-first)
- CLEAR_ON_RESET, 1, 1 = sweep every word to CLEAR_VALUE after reset; 0 = skip the sweep
- CLEAR_VALUE, 0, DWIDTH-bit fill value written by the sweep

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_en  in  1  port A access request this cycle
- a_load  in  1  port A write (when a_en=1); 0 = read
- a_addr  in  AWIDTH  port A word address
- a_d  in  DWIDTH  port A write data
- a_q  out  DWIDTH  port A read data, registered
- a_valid  out  1  a_q updated by a read this cycle (one-cycle pulse)
- b_en, b_load, b_addr, b_d, b_q, b_valid: same as port A, for port B
- busy  out  1  clear sweep in progress; all requests ignored
- err  out  1  one-cycle pulse: out-of-range access or dropped B write (see collision)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - a_q, b_q = 0; a_valid, b_valid, err = 0.
  - FSM enters CLEAR if CLEAR_ON_RESET=1, otherwise READY; sweep pointer = 0.
  - busy is asserted asynchronously with reset when CLEAR_ON_RESET=1.
  - Memory contents are not reset directly.
- FSM states CLEAR, READY:
  - CLEAR: write CLEAR_VALUE at the pointer each cycle, pointer+1; after writing WORDS-1, go to READY on the next edge.
  - busy=1 for exactly WORDS cycles after rst_n deasserts.
  - READY: normal operation.
  - Reset mid-sweep restarts the sweep from 0.
- While busy: a_en/b_en are ignored; no writes, no valid pulses, no err, q outputs hold.
- Read: en=1, load=0, addr < WORDS → q = mem[addr] on the next edge with valid=1 (latency 1). q holds between reads.
- Write: en=1, load=1, addr < WORDS → mem[addr] = d at the edge.
  - Same-port write also updates q per RDW_MODE (old or new word); valid=0 for writes.
- Out-of-range (addr >= WORDS, only possible when WORDS < 2**AWIDTH):
  - Write is dropped.
  - Read returns 0 with valid=1.
  - err pulses for one cycle.
- Cross-port, same address, same cycle:
  - Both write: A wins, B's write is dropped, err pulses.
  - One writes, the other reads: the reader gets old data (RDW_MODE=0) or the writer's data (RDW_MODE=1).
  - Both read: both get mem[addr].
- Addresses are unsigned. Pointer width is AWIDTH+1 internally so the terminal count is exact when WORDS = 2**AWIDTH.

Decomposition:
- Shared package tc_pkg: FSM state enum (ST_CLEAR, ST_READY); RDW_OLD=0 / RDW_NEW=1 constants; default DWIDTH/AWIDTH.
- One sub-module is natural: tc_ram_clr_seq (sweep counter + FSM, outputs busy, clr_we, clr_addr). The storage array and port logic stay in tc_ram_dp.

Test Plan:
- Clear: WORDS=16, CLEAR_VALUE=16'hA5A5, release rst_n → busy high exactly 16 cycles; then B reads of addresses 0..15 all return 16'hA5A5 with b_valid pulses.
- Basic R/W: A writes 16'hD000 @0x000 and 16'h300C @0x00C, then reads them → a_q=16'hD000, then 16'h300C, each one cycle after its request, a_valid=1.
- RDW: A writes 16'h1234 @5 (old 16'h0000) while B reads @5 → b_q=16'h0000 for RDW_MODE=0, 16'h1234 for RDW_MODE=1.
- Write collision: A writes 16'h1111, B writes 16'h2222 @7 in the same cycle → err pulses once; a later read @7 returns 16'h1111.
- Range: WORDS=12, AWIDTH=4, A writes 16'hFFFF @13, then reads @13 → err pulses each time; a_q=0 with a_valid=1; no array word changes.
- Reset mid-sweep: assert rst_n=0 at sweep pointer 6 → busy stays high; after release, busy lasts a full WORDS cycles; requests issued during busy produce no valid pulse and no write.
